// File: rtl/ram_port_arbiter.sv
// Round-robin read arbiter, write forwarder and init sweeper for a shared 1R1W buffer RAM.
// Optional RAW bypass of in-flight reads is enabled by defining RAM_ARB_RAW_BYPASS_EN.
module ram_port_arbiter #(
  parameter int                    DATA_WIDTH = 10,
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    NUM_REQ    = 4,
  parameter int                    RD_LAT     = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_gnt,
  output logic [NUM_REQ-1:0]            rsp_vld,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  input  logic                          wr_req,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_ack,
  input  logic                          init_start,
  output logic                          init_busy,
  output logic                          init_done,
  output logic                          ram_rd_req,
  output logic [ADDR_WIDTH-1:0]         ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]         ram_rd_data,
  output logic                          ram_wr_req,
  output logic [ADDR_WIDTH-1:0]         ram_wr_addr,
  output logic [DATA_WIDTH-1:0]         ram_wr_data
);
  localparam int            PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW:0]   NREQ = (PW+1)'(NUM_REQ);

  typedef enum logic {RUN, INIT} state_t;

  state_t                               state, state_n;
  logic [ADDR_WIDTH:0]                  cnt;
  logic                                 sweep_end;
  logic [PW-1:0]                        rr_ptr, gnt_idx, nxt_ptr;
  logic [PW:0]                          cand, inc;
  logic                                 found;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_arr;
  logic [NUM_REQ-1:0]                   tag_pipe [1:RD_LAT];

  assign addr_arr  = req_addr;
  assign sweep_end = cnt[ADDR_WIDTH];

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(j);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req_vld[cand[PW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
    inc     = {1'b0, gnt_idx} + 1'b1;
    nxt_ptr = (inc >= NREQ) ? '0 : inc[PW-1:0];
  end

  always_comb begin
    state_n     = state;
    req_gnt     = '0;
    ram_rd_req  = 1'b0;
    ram_rd_addr = '0;
    wr_ack      = 1'b0;
    ram_wr_req  = 1'b0;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    init_busy   = 1'b0;
    init_done   = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (init_start) state_n = INIT;
          if (found) begin
            req_gnt     = NUM_REQ'(1) << gnt_idx;
            ram_rd_req  = 1'b1;
            ram_rd_addr = addr_arr[gnt_idx];
          end
          wr_ack      = wr_req;
          ram_wr_req  = wr_req;
          ram_wr_addr = wr_addr;
          ram_wr_data = wr_data;
        end
        INIT: begin
          if (sweep_end) begin
            init_done = 1'b1;
            state_n   = RUN;
          end else begin
            init_busy   = 1'b1;
            ram_wr_req  = 1'b1;
            ram_wr_addr = cnt[ADDR_WIDTH-1:0];
            ram_wr_data = INIT_VALUE;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RUN;
      rr_ptr <= '0;
      cnt    <= '0;
      for (int s = 1; s <= RD_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      state <= state_n;
      if (ram_rd_req) rr_ptr <= nxt_ptr;
      if (state == INIT) cnt <= sweep_end ? '0 : cnt + 1'b1;
      tag_pipe[1] <= req_gnt;
      for (int s = 2; s <= RD_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign rsp_vld = rst_n ? tag_pipe[RD_LAT] : '0;

`ifdef RAM_ARB_RAW_BYPASS_EN
  typedef struct packed {
    logic                  hit;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } byp_t;

  byp_t byp [1:RD_LAT];

  // Any write landing on an in-flight read address (grant cycle included) overrides the RAM word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 1; s <= RD_LAT; s++) byp[s] <= '0;
    end else begin
      byp[1].hit  <= ram_wr_req && (ram_wr_addr == ram_rd_addr);
      byp[1].addr <= ram_rd_addr;
      byp[1].data <= ram_wr_data;
      for (int s = 2; s <= RD_LAT; s++) begin
        if (ram_wr_req && (ram_wr_addr == byp[s-1].addr)) begin
          byp[s].hit  <= 1'b1;
          byp[s].addr <= byp[s-1].addr;
          byp[s].data <= ram_wr_data;
        end else begin
          byp[s] <= byp[s-1];
        end
      end
    end
  end

  assign rsp_data = byp[RD_LAT].hit ? byp[RD_LAT].data : ram_rd_data;
`else
  assign rsp_data = ram_rd_data;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, cycle reference model, vector table, corner sequences, random traffic.
module tb_ram_port_arbiter;
  localparam int              DW    = 10;
  localparam int              AW    = 4;
  localparam int              NR    = 4;
  localparam int              RL    = 1;
  localparam int              DEPTH = 1 << AW;
  localparam logic [DW-1:0]   IV    = 10'h2C3;

  logic                clk, rst_n;
  logic [NR-1:0]       req_vld, req_gnt, rsp_vld;
  logic [NR*AW-1:0]    req_addr;
  logic [NR-1:0][AW-1:0] raddr;
  logic [DW-1:0]       rsp_data, wr_data, ram_rd_data, ram_wr_data;
  logic                wr_req, wr_ack, init_start, init_busy, init_done;
  logic [AW-1:0]       wr_addr, ram_rd_addr, ram_wr_addr;
  logic                ram_rd_req, ram_wr_req;

  assign req_addr = raddr;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .RD_LAT(RL), .INIT_VALUE(IV)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_addr(req_addr), .req_gnt(req_gnt),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
    .ram_rd_req(ram_rd_req), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_req(ram_wr_req), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1R1W RAM, one-cycle read, same-cycle collision returns the old word.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;
  always @(posedge clk) begin
    if (ram_rd_req) rd_q <= mem[ram_rd_addr];
    if (ram_wr_req) mem[ram_wr_addr] <= ram_wr_data;
  end
  assign ram_rd_data = rd_q;

  int errors = 0, checks = 0;

  // Reference model state
  int            m_rr = 0, m_sweep = 0;
  bit            m_init = 1'b0;
  logic [DW-1:0] m_mem [DEPTH];
  logic [NR-1:0] m_tag = '0;
  logic [DW-1:0] m_dat;
  logic [NR-1:0] last_gnt;
  logic          last_ack;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare this cycle's outputs with the model, then advance the model past the coming edge.
  task automatic eval();
    logic [NR-1:0] eg;
    logic [AW-1:0] era, ewa;
    logic [DW-1:0] ewd;
    logic ewr, eack, ebusy, edone, chk_wa;
    int gi;
    #3;
    eg = '0; era = '0; ewa = '0; ewd = '0; gi = 0;
    ewr = 1'b0; eack = 1'b0; ebusy = 1'b0; edone = 1'b0; chk_wa = 1'b0;
    if (rst_n && !m_init) begin
      for (int j = 0; j < NR; j++) begin
        int i;
        i = (m_rr + j) % NR;
        if (eg == '0 && ((req_vld >> i) & NR'(1)) != '0) begin
          eg  = NR'(1) << i;
          era = AW'(req_addr >> (AW * i));
          gi  = i;
        end
      end
      eack = wr_req; ewr = wr_req; ewa = wr_addr; ewd = wr_data; chk_wa = 1'b1;
    end else if (rst_n) begin
      if (m_sweep < DEPTH) begin
        ewr = 1'b1; ebusy = 1'b1; ewa = AW'(m_sweep); ewd = IV; chk_wa = 1'b1;
      end else edone = 1'b1;
    end
    check("req_gnt",    32'(req_gnt),    32'(eg));
    check("ram_rd_req", 32'(ram_rd_req), 32'(|eg));
    check("ram_rd_addr",32'(ram_rd_addr),32'(era));
    check("wr_ack",     32'(wr_ack),     32'(eack));
    check("ram_wr_req", 32'(ram_wr_req), 32'(ewr));
    if (chk_wa) begin
      check("ram_wr_addr", 32'(ram_wr_addr), 32'(ewa));
      check("ram_wr_data", 32'(ram_wr_data), 32'(ewd));
    end
    check("init_busy", 32'(init_busy), 32'(ebusy));
    check("init_done", 32'(init_done), 32'(edone));
    check("rsp_vld",   32'(rsp_vld),   rst_n ? 32'(m_tag) : 32'd0);
    if (rst_n && m_tag != '0) check("rsp_data", 32'(rsp_data), 32'(m_dat));
    last_gnt = eg;
    last_ack = eack;
    if (!rst_n) begin
      m_rr = 0; m_init = 1'b0; m_sweep = 0; m_tag = '0;
    end else begin
      m_tag = eg;
      if (eg != '0) begin
        m_dat = m_mem[era];
`ifdef RAM_ARB_RAW_BYPASS_EN
        if (ewr && ewa == era) m_dat = ewd;
`endif
        m_rr = (gi + 1) % NR;
      end
      if (ewr) m_mem[ewa] = ewd;
      if (m_init) begin
        if (m_sweep == DEPTH) begin m_init = 1'b0; m_sweep = 0; end
        else m_sweep++;
      end else if (init_start) begin
        m_init = 1'b1; m_sweep = 0;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    eval();
    adv();
  endtask

  typedef struct {
    logic [NR-1:0] vld;
    logic [NR-1:0] gnt;
    logic [NR-1:0] rsp;
  } vec_t;

  vec_t tbl [14];
  logic [NR-1:0] pend;
  logic          wr_pend;
  int busy_cnt, done_at, gnt_at, done_cnt;
  logic ack_at_gnt;

  initial begin
    tbl[0]  = '{4'b1111, 4'b0001, 4'b0000};
    tbl[1]  = '{4'b1111, 4'b0010, 4'b0001};
    tbl[2]  = '{4'b1111, 4'b0100, 4'b0010};
    tbl[3]  = '{4'b1111, 4'b1000, 4'b0100};
    tbl[4]  = '{4'b1111, 4'b0001, 4'b1000};
    tbl[5]  = '{4'b1111, 4'b0010, 4'b0001};
    tbl[6]  = '{4'b1111, 4'b0100, 4'b0010};
    tbl[7]  = '{4'b1111, 4'b1000, 4'b0100};
    tbl[8]  = '{4'b0101, 4'b0001, 4'b1000};
    tbl[9]  = '{4'b0101, 4'b0100, 4'b0001};
    tbl[10] = '{4'b0101, 4'b0001, 4'b0100};
    tbl[11] = '{4'b0101, 4'b0100, 4'b0001};
    tbl[12] = '{4'b0100, 4'b0100, 4'b0100};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0100};

    rst_n = 1'b0; req_vld = '1; wr_req = 1'b1; wr_addr = '0; wr_data = '0; init_start = 1'b0;
    for (int i = 0; i < NR; i++) raddr[i] = AW'(3 * i + 1);

    // Reset with everything requesting: quiet outputs.
    for (int c = 0; c < 3; c++) tick();
    rst_n = 1'b1; req_vld = '0;

    // Fill the RAM through the write port.
    for (int a = 0; a < DEPTH; a++) begin
      wr_req = 1'b1; wr_addr = AW'(a); wr_data = DW'($urandom);
      tick();
    end
    wr_req = 1'b0;

    // Round-robin and fairness vectors.
    for (int k = 0; k < 14; k++) begin
      req_vld = tbl[k].vld;
      eval();
      check("tbl_gnt", 32'(req_gnt), 32'(tbl[k].gnt));
      check("tbl_rsp", 32'(rsp_vld), 32'(tbl[k].rsp));
      adv();
    end

    // Init sweep with a read and a write held throughout.
    init_start = 1'b1;
    tick();
    init_start = 1'b0; req_vld = 4'b0001; raddr[0] = 4'd5;
    wr_req = 1'b1; wr_addr = 4'd3; wr_data = 10'h111;
    busy_cnt = 0; done_at = -1; gnt_at = -1; ack_at_gnt = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      eval();
      if (init_busy) busy_cnt++;
      if (init_done) done_at = c;
      if (req_gnt[0]) begin gnt_at = c; ack_at_gnt = wr_ack; end
      adv();
      if (gnt_at >= 0) break;
    end
    req_vld = '0; wr_req = 1'b0;
    check("init_busy_cycles", 32'(busy_cnt), 32'd16);
    check("init_done_cycle",  32'(done_at),  32'd17);
    check("init_gnt_cycle",   32'(gnt_at),   32'd18);
    check("init_ack_at_gnt",  32'(ack_at_gnt), 32'd1);
    tick();

    // Same-cycle write/read collision on address 7.
    raddr[2] = 4'd7;
    wr_req = 1'b1; wr_addr = 4'd7; wr_data = 10'h0AA;
    tick();
    wr_data = 10'h155; req_vld = 4'b0100;
    tick();
    wr_req = 1'b0; req_vld = '0;
    eval();
    check("collision_vld", 32'(rsp_vld), 32'(4'b0100));
`ifdef RAM_ARB_RAW_BYPASS_EN
    check("collision_data", 32'(rsp_data), 32'h155);
`else
    check("collision_data", 32'(rsp_data), 32'h0AA);
`endif
    adv();

    // Reset in the middle of a sweep, then restart from address 0.
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    rst_n = 1'b0;
    eval();
    check("midrst_busy", 32'(init_busy), 32'd0);
    adv();
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      eval();
      if (init_done) done_cnt++;
      adv();
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    eval();
    check("restart_addr", 32'(ram_wr_addr), 32'd0);
    check("restart_busy", 32'(init_busy), 32'd1);
    adv();
    for (int c = 0; c < 30 && m_init; c++) begin
      eval();
      if (init_done) done_cnt++;
      adv();
    end
    check("restart_done_pulses", 32'(done_cnt), 32'd1);

    // Random traffic against the model; clients hold until served.
    pend = '0; wr_pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          raddr[i] = AW'($urandom_range(0, DEPTH - 1));
        end
      end
      if (!wr_pend && $urandom_range(0, 1) == 1) begin
        wr_pend = 1'b1;
        wr_addr = AW'($urandom_range(0, DEPTH - 1));
        wr_data = DW'($urandom);
      end
      req_vld = pend; wr_req = wr_pend;
      init_start = ($urandom_range(0, 79) == 0);
      eval();
      pend = pend & ~last_gnt;
      if (last_ack) wr_pend = 1'b0;
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
